// File: rtl/regfile_writeback.sv
// Writeback merge for the 32x32 register file: ALU results win the single write port,
// a colliding load is parked in a 1-entry buffer, and a scoreboard tracks outstanding loads.
module regfile_writeback #(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_issue,
   input  logic [4:0]      ld_issue_rd,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [4:0]      ld_rd,
   input  logic [XLEN-1:0] ld_data,
   output logic            rf_write,
   output logic [4:0]      rf_wa,
   output logic [XLEN-1:0] rf_wdata,
   output logic [31:0]     pending
);
   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_t;

   localparam int CW = $clog2(MAX_WAIT + 1);

   logic          buf_full;
   wb_t           buf_q;
   logic [CW-1:0] wait_cnt;
   logic          rf_ld;
   logic [31:1]   pend_q;

   wb_t  sel;
   logic sel_vld, sel_ld, drain, alu_acc, ld_acc;

   assign ld_ready  = !buf_full;
   assign alu_ready = !(buf_full && (wait_cnt >= CW'(MAX_WAIT)));
   assign alu_acc   = alu_valid && alu_ready;
   assign ld_acc    = ld_valid && ld_ready;

   always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      sel_ld  = 1'b0;
      drain   = 1'b0;
      if (alu_acc) begin
         sel     = '{rd: alu_rd, data: alu_data};
         sel_vld = 1'b1;
      end else if (buf_full) begin
         sel     = buf_q;
         sel_vld = 1'b1;
         sel_ld  = 1'b1;
         drain   = 1'b1;
      end else if (ld_valid) begin
         sel     = '{rd: ld_rd, data: ld_data};
         sel_vld = 1'b1;
         sel_ld  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_write <= 1'b0;
         rf_wa    <= '0;
         rf_wdata <= '0;
         rf_ld    <= 1'b0;
         buf_full <= 1'b0;
         buf_q    <= '0;
         wait_cnt <= '0;
      end else begin
         // x0 results are consumed but never reach the port
         rf_write <= sel_vld && (sel.rd != 5'd0);
         rf_ld    <= sel_vld && sel_ld && (sel.rd != 5'd0);
         if (sel_vld) begin
            rf_wa    <= sel.rd;
            rf_wdata <= sel.data;
         end
         if (alu_acc && ld_acc) begin
            buf_full <= 1'b1;
            buf_q    <= '{rd: ld_rd, data: ld_data};
         end else if (drain) begin
            buf_full <= 1'b0;
         end
         if (buf_full && !drain)
            wait_cnt <= (wait_cnt >= CW'(MAX_WAIT)) ? wait_cnt : wait_cnt + CW'(1);
         else
            wait_cnt <= '0;
      end
   end

   // A pending bit drops when the RF actually takes the load write; a same-edge issue wins.
   for (genvar r = 1; r < 32; r++) begin : g_sb
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            pend_q[r] <= 1'b0;
         else if (ld_issue && (ld_issue_rd == 5'(r)))
            pend_q[r] <= 1'b1;
         else if (rf_write && rf_ld && (rf_wa == 5'(r)))
            pend_q[r] <= 1'b0;
      end
   end

   assign pending = {pend_q, 1'b0};
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed table-driven bench for regfile_writeback plus a hand-written async-reset sequence.
module tb_regfile_writeback;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_issue;
   logic [4:0]  ld_issue_rd;
   logic        ld_valid, ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        rf_write;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wdata;
   logic [31:0] pending;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_writeback #(.XLEN(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .rf_write(rf_write), .rf_wa(rf_wa), .rf_wdata(rf_wdata), .pending(pending)
   );

   // inputs for one cycle, and the outputs expected in the following cycle
   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        li;
      logic [4:0]  lir;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldd;
      logic        ew;
      logic [4:0]  ewa;
      logic [31:0] ewd;
      logic [31:0] ep;
      logic        ear;
      logic        elr;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad,
                               logic li, logic [4:0] lir,
                               logic lv, logic [4:0] lrd, logic [31:0] ldd,
                               logic ew, logic [4:0] ewa, logic [31:0] ewd,
                               logic [31:0] ep, logic ear, logic elr);
      vec_t v;
      v.av = av; v.ard = ard; v.ad = ad; v.li = li; v.lir = lir;
      v.lv = lv; v.lrd = lrd; v.ldd = ldd;
      v.ew = ew; v.ewa = ewa; v.ewd = ewd; v.ep = ep; v.ear = ear; v.elr = elr;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      ld_issue = 0; ld_issue_rd = 0;
      ld_valid = 0; ld_rd = 0; ld_data = 0;
   endtask

   initial begin
      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset rf_write", 32'(rf_write), 0);
      chk("reset rf_wa", 32'(rf_wa), 0);
      chk("reset rf_wdata", rf_wdata, 0);
      chk("reset pending", pending, 0);
      chk("reset ld_ready", 32'(ld_ready), 1);
      chk("reset alu_ready", 32'(alu_ready), 1);
      rst_n = 1'b1;

      //           av ard  adata         li lir lv lrd ldata        ew ewa ewd           pend         ar lr
      vt.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,             1, 5, 32'hDEADBEEF, 32'h0,       1, 1));
      vt.push_back(mk(0, 0, 0,            1, 7, 0, 0, 0,             0, 0, 0,            32'h80,      1, 1));
      vt.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,             0, 0, 0,            32'h80,      1, 1));
      vt.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,             0, 0, 0,            32'h80,      1, 1));
      vt.push_back(mk(0, 0, 0,            0, 0, 1, 7, 32'h1234,      1, 7, 32'h1234,     32'h80,      1, 1));
      vt.push_back(mk(0, 0, 0,            1, 4, 0, 0, 0,             0, 0, 0,            32'h10,      1, 1));
      // ALU/load collision: load buffered, pending kept
      vt.push_back(mk(1, 3, 32'h33,       0, 0, 1, 4, 32'h44,        1, 3, 32'h33,       32'h10,      1, 0));
      vt.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,             1, 4, 32'h44,       32'h10,      1, 1));
      vt.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,             0, 0, 0,            32'h0,       1, 1));
      // buffered load starved by a stream of ALU writes
      vt.push_back(mk(1, 1, 32'hA1,       0, 0, 1, 2, 32'hB2,        1, 1, 32'hA1,       32'h0,       1, 0));
      vt.push_back(mk(1, 8, 32'hA2,       0, 0, 0, 0, 0,             1, 8, 32'hA2,       32'h0,       1, 0));
      vt.push_back(mk(1, 9, 32'hA3,       0, 0, 0, 0, 0,             1, 9, 32'hA3,       32'h0,       1, 0));
      vt.push_back(mk(1, 10, 32'hA4,      0, 0, 0, 0, 0,             1, 10, 32'hA4,      32'h0,       1, 0));
      vt.push_back(mk(1, 11, 32'hA5,      0, 0, 0, 0, 0,             1, 11, 32'hA5,      32'h0,       0, 0));
      vt.push_back(mk(1, 12, 32'hA6,      0, 0, 1, 13, 32'hC0,       1, 2, 32'hB2,       32'h0,       1, 1));
      vt.push_back(mk(1, 12, 32'hA6,      0, 0, 0, 0, 0,             1, 12, 32'hA6,      32'h0,       1, 1));
      // x0 destinations
      vt.push_back(mk(1, 0, 32'hFF,       1, 0, 0, 0, 0,             0, 0, 0,            32'h0,       1, 1));
      vt.push_back(mk(0, 0, 0,            0, 0, 1, 0, 32'hEE,        0, 0, 0,            32'h0,       1, 1));
      // reissue on the clearing edge, and ALU write to a pending register
      vt.push_back(mk(0, 0, 0,            1, 6, 0, 0, 0,             0, 0, 0,            32'h40,      1, 1));
      vt.push_back(mk(0, 0, 0,            0, 0, 1, 6, 32'h66,        1, 6, 32'h66,       32'h40,      1, 1));
      vt.push_back(mk(0, 0, 0,            1, 6, 0, 0, 0,             0, 0, 0,            32'h40,      1, 1));
      vt.push_back(mk(1, 6, 32'h99,       0, 0, 0, 0, 0,             1, 6, 32'h99,       32'h40,      1, 1));
      vt.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,             0, 0, 0,            32'h40,      1, 1));
      vt.push_back(mk(0, 0, 0,            0, 0, 1, 6, 32'h77,        1, 6, 32'h77,       32'h40,      1, 1));
      vt.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,             0, 0, 0,            32'h0,       1, 1));

      foreach (vt[i]) begin
         alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].ad;
         ld_issue = vt[i].li; ld_issue_rd = vt[i].lir;
         ld_valid = vt[i].lv; ld_rd = vt[i].lrd; ld_data = vt[i].ldd;
         @(negedge clk);
         chk($sformatf("v%0d rf_write", i), 32'(rf_write), 32'(vt[i].ew));
         if (vt[i].ew) begin
            chk($sformatf("v%0d rf_wa", i), 32'(rf_wa), 32'(vt[i].ewa));
            chk($sformatf("v%0d rf_wdata", i), rf_wdata, vt[i].ewd);
         end
         chk($sformatf("v%0d pending", i), pending, vt[i].ep);
         chk($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vt[i].ear));
         chk($sformatf("v%0d ld_ready", i), 32'(ld_ready), 32'(vt[i].elr));
      end

      // async reset while a buffered load is waiting to drain
      alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
      ld_valid = 1; ld_rd = 2; ld_data = 32'h22;
      ld_issue = 1; ld_issue_rd = 9;
      @(negedge clk);
      drive_idle();
      chk("pre-reset ld_ready", 32'(ld_ready), 0);
      chk("pre-reset pending", pending, 32'h200);
      chk("pre-reset rf_write", 32'(rf_write), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rf_write", 32'(rf_write), 0);
      chk("async rf_wa", 32'(rf_wa), 0);
      chk("async rf_wdata", rf_wdata, 0);
      chk("async pending", pending, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-reset ld_ready", 32'(ld_ready), 1);
      chk("post-reset rf_write", 32'(rf_write), 0);
      chk("post-reset alu_ready", 32'(alu_ready), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
